// File: rtl/sonic_pkg.sv
// Shared definitions for the SR04 distance path: widths, ASCII constants and
// the UART reporter state encoding.
package sonic_pkg;

  localparam int unsigned DIST_W = 10;

  localparam logic [7:0] ASC_ZERO = 8'h30;
  localparam logic [7:0] ASC_SP   = 8'h20;
  localparam logic [7:0] ASC_C    = 8'h63;
  localparam logic [7:0] ASC_M    = 8'h6D;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StConv  = 3'd1,
    StSend  = 3'd2,
    StGuard = 3'd3,
    StHold  = 3'd4
  } rep_state_e;

  function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
    return ASC_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/bcd_dd_seq.sv
// Iterative double-dabble: converts a DIST_W-bit binary value to three BCD
// digits, one shift-and-adjust step per clock, DIST_W steps per conversion.
module bcd_dd_seq
  import sonic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIST_W-1:0] bin,
  output logic              done,
  output logic [11:0]       bcd
);

  logic [DIST_W+11:0] sh_q;
  logic [3:0]         cnt_q;
  logic               run_q;
  logic [11:0]        bcd_adj;

  // Nibbles >= 5 get +3 so the following shift carries correctly into the next digit.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 3; i++) begin
      if (sh_q[DIST_W+4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = sh_q[DIST_W+4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = sh_q[DIST_W+4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= 4'd0;
      run_q <= 1'b0;
    end else if (start) begin
      sh_q  <= {12'd0, bin};
      cnt_q <= 4'd0;
      run_q <= 1'b1;
    end else if (run_q) begin
      sh_q  <= {bcd_adj[10:0], sh_q[DIST_W-1:0], 1'b0};
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'(DIST_W - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

  // High during the final iteration; bcd holds the result from the next cycle on.
  assign done = run_q && (cnt_q == 4'(DIST_W - 1));
  assign bcd  = sh_q[DIST_W+11:DIST_W];

endmodule

// File: rtl/dist_uart_reporter.sv
// Converts each completed distance measurement to ASCII decimal and streams the
// frame ("ddd cm\r\n" or "ddd\r\n") into uart_tx via its start/busy handshake.
module dist_uart_reporter
  import sonic_pkg::*;
#(
  parameter int unsigned SEND_UNITS = 1,
  parameter int unsigned MAX_DIST   = 999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dist_done,
  input  logic [DIST_W-1:0] distance,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              overrun
);

  localparam logic [DIST_W-1:0] MaxDist = DIST_W'(MAX_DIST);
  localparam logic [2:0]        LastIdx = (SEND_UNITS != 0) ? 3'd7 : 3'd4;

  rep_state_e        state_q;
  logic [2:0]        idx_q;
  logic [DIST_W-1:0] dist_clamped;
  logic              dd_start;
  logic              dd_done;
  logic [11:0]       bcd;
  logic [7:0]        frame_byte;

  assign dist_clamped = (distance > MaxDist) ? MaxDist : distance;
  assign dd_start     = dist_done && (state_q == StIdle);
  assign busy         = (state_q != StIdle);

  bcd_dd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (dd_start),
    .bin   (dist_clamped),
    .done  (dd_done),
    .bcd   (bcd)
  );

  always_comb begin
    frame_byte = ASC_LF;
    case (idx_q)
      3'd0:    frame_byte = digit_ascii(bcd[11:8]);
      3'd1:    frame_byte = digit_ascii(bcd[7:4]);
      3'd2:    frame_byte = digit_ascii(bcd[3:0]);
      3'd3:    frame_byte = (SEND_UNITS != 0) ? ASC_SP : ASC_CR;
      3'd4:    frame_byte = (SEND_UNITS != 0) ? ASC_C : ASC_LF;
      3'd5:    frame_byte = ASC_M;
      3'd6:    frame_byte = ASC_CR;
      default: frame_byte = ASC_LF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 3'd0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      overrun  <= dist_done && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (dist_done) state_q <= StConv;
        end
        StConv: begin
          if (dd_done) begin
            state_q <= StSend;
            idx_q   <= 3'd0;
          end
        end
        StSend: begin
          if (!tx_busy) begin
            tx_data  <= frame_byte;
            tx_start <= 1'b1;
            state_q  <= StGuard;
          end
        end
        // uart_tx raises busy one cycle after accepting a start, so skip that cycle.
        StGuard: state_q <= StHold;
        StHold: begin
          if (!tx_busy) begin
            if (idx_q == LastIdx) begin
              state_q <= StIdle;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dist_uart_reporter.sv
// Bench for dist_uart_reporter: two instances (with and without units) share
// stimulus; each has its own uart_tx busy model and byte monitor.
module tb_dist_uart_reporter;

  localparam int BYTE_CYC = 20;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       dist_done;
  logic [9:0] distance;
  logic       force_busy;

  logic       tx_busy_u, tx_start_u, busy_u, overrun_u;
  logic [7:0] tx_data_u;
  logic       tx_busy_n, tx_start_n, busy_n, overrun_n;
  logic [7:0] tx_data_n;

  int cyc = 0;
  int cnt_u = 0, cnt_n = 0;
  int total = 0, bad = 0;
  int first_u = 0, first_n = 0;
  int ov_u = 0, ov_n = 0;
  int n_edge;
  bq_t q_u, q_n;

  dist_uart_reporter #(.SEND_UNITS(1), .MAX_DIST(999)) dut_u (
    .clk       (clk),
    .rst       (rst),
    .dist_done (dist_done),
    .distance  (distance),
    .tx_busy   (tx_busy_u),
    .tx_start  (tx_start_u),
    .tx_data   (tx_data_u),
    .busy      (busy_u),
    .overrun   (overrun_u)
  );

  dist_uart_reporter #(.SEND_UNITS(0), .MAX_DIST(999)) dut_n (
    .clk       (clk),
    .rst       (rst),
    .dist_done (dist_done),
    .distance  (distance),
    .tx_busy   (tx_busy_n),
    .tx_start  (tx_start_n),
    .tx_data   (tx_data_n),
    .busy      (busy_n),
    .overrun   (overrun_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy from the cycle after an accepted start, BYTE_CYC cycles long.
  assign tx_busy_u = force_busy | (cnt_u != 0);
  assign tx_busy_n = force_busy | (cnt_n != 0);

  always @(posedge clk) begin
    if (rst) cnt_u <= 0;
    else if (tx_start_u) cnt_u <= BYTE_CYC;
    else if (cnt_u != 0) cnt_u <= cnt_u - 1;
    if (rst) cnt_n <= 0;
    else if (tx_start_n) cnt_n <= BYTE_CYC;
    else if (cnt_n != 0) cnt_n <= cnt_n - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start_u) begin
      q_u.push_back(tx_data_u);
      if (q_u.size() == 1) first_u = cyc;
      chk("start_while_busy_u", {31'd0, tx_busy_u}, 32'd0);
    end
    if (tx_start_n) begin
      q_n.push_back(tx_data_n);
      if (q_n.size() == 1) first_n = cyc;
      chk("start_while_busy_n", {31'd0, tx_busy_n}, 32'd0);
    end
    if (overrun_u) ov_u++;
    if (overrun_n) ov_n++;
  end

  // Reference frame computed from decimal arithmetic on the clamped distance.
  function automatic bq_t exp_frame(input int d, input bit units);
    bq_t f;
    int v;
    v = (d > 999) ? 999 : d;
    f.push_back(8'(48 + v / 100));
    f.push_back(8'(48 + (v / 10) % 10));
    f.push_back(8'(48 + v % 10));
    if (units) begin
      f.push_back(8'h20);
      f.push_back(8'h63);
      f.push_back(8'h6D);
    end
    f.push_back(8'h0D);
    f.push_back(8'h0A);
    return f;
  endfunction

  task automatic start_frame(input logic [9:0] d);
    @(negedge clk);
    q_u.delete();
    q_n.delete();
    distance  = d;
    dist_done = 1'b1;
    @(negedge clk);
    n_edge    = cyc;
    dist_done = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while ((busy_u || busy_n) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy_u | busy_n}, 32'd0);
  endtask

  task automatic chk_frame(input string tag, input int d);
    bq_t eu, en;
    logic [31:0] obs;
    eu = exp_frame(d, 1'b1);
    en = exp_frame(d, 1'b0);
    chk($sformatf("%s_len_u", tag), q_u.size(), eu.size());
    chk($sformatf("%s_len_n", tag), q_n.size(), en.size());
    for (int i = 0; i < eu.size(); i++) begin
      obs = (i < q_u.size()) ? {24'd0, q_u[i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_u_byte%0d", tag, i), obs, {24'd0, eu[i]});
    end
    for (int i = 0; i < en.size(); i++) begin
      obs = (i < q_n.size()) ? {24'd0, q_n[i]} : 32'hFFFF_FFFF;
      chk($sformatf("%s_n_byte%0d", tag, i), obs, {24'd0, en[i]});
    end
  endtask

  initial begin
    int dl[$];
    int d, r, k;

    rst = 1'b1;
    dist_done = 1'b0;
    distance = '0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start_u | tx_start_n}, 32'd0);
    chk("rst_busy", {31'd0, busy_u | busy_n}, 32'd0);
    chk("rst_overrun", {31'd0, overrun_u | overrun_n}, 32'd0);
    chk("rst_tx_data_u", {24'd0, tx_data_u}, 32'd0);
    chk("rst_tx_data_n", {24'd0, tx_data_n}, 32'd0);
    rst = 1'b0;

    // Directed boundary values followed by random distances.
    dl = '{123, 7, 0, 1023, 1000, 999};
    repeat (4) dl.push_back(int'($urandom_range(1023, 0)));
    foreach (dl[j]) begin
      d = dl[j];
      start_frame(10'(d));
      wait_idle(1000);
      chk($sformatf("lat_u_%0d", d), first_u - n_edge, 11);
      chk($sformatf("lat_n_%0d", d), first_n - n_edge, 11);
      chk_frame($sformatf("f%0d", d), d);
    end
    chk("no_spurious_overrun", ov_u + ov_n, 0);

    // Second dist_done during byte 3 is dropped and flagged.
    d = 321;
    start_frame(10'(d));
    k = 0;
    while (q_u.size() < 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("ovr_reach_byte3", q_u.size(), 3);
    distance  = 10'($urandom_range(1023, 0));
    dist_done = 1'b1;
    @(negedge clk);
    dist_done = 1'b0;
    chk("ovr_pulse_u", {31'd0, overrun_u}, 32'd1);
    chk("ovr_pulse_n", {31'd0, overrun_n}, 32'd1);
    @(negedge clk);
    chk("ovr_one_cycle", {31'd0, overrun_u | overrun_n}, 32'd0);
    wait_idle(1000);
    chk_frame("ovr", d);
    repeat (50) @(negedge clk);
    chk("ovr_no_refire_u", q_u.size(), 8);
    chk("ovr_no_refire_n", q_n.size(), 5);
    chk("ovr_count_u", ov_u, 1);
    chk("ovr_count_n", ov_n, 1);

    // uart_tx stuck busy: no start until it clears, then one pulse.
    force_busy = 1'b1;
    d = int'($urandom_range(1023, 0));
    start_frame(10'(d));
    repeat (500) @(negedge clk);
    chk("stuck_no_start_u", q_u.size(), 0);
    chk("stuck_no_start_n", q_n.size(), 0);
    chk("stuck_busy", {31'd0, busy_u & busy_n}, 32'd1);
    r = cyc;
    force_busy = 1'b0;
    wait_idle(1000);
    chk("stuck_release_u", first_u - r, 1);
    chk("stuck_release_n", first_n - r, 1);
    chk_frame("stuck", d);

    // Reset while holding after byte 2 abandons the frame.
    start_frame(10'd500);
    k = 0;
    while (q_u.size() < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_start", {31'd0, tx_start_u | tx_start_n}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_u | busy_n}, 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_rst_abandon_u", q_u.size(), 2);
    chk("mid_rst_abandon_n", q_n.size(), 2);
    start_frame(10'd45);
    wait_idle(1000);
    chk("post_rst_lat_u", first_u - n_edge, 11);
    chk_frame("post_rst45", 45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dist_uart_reporter.md
Name: dist_uart_reporter

Overview:
- Downstream consumer of the ultrasonic distance result, running in parallel with the FND display path.
- On each completed measurement it converts the 10-bit cm distance to three decimal digits with an iterative double-dabble.
- It then streams an ASCII frame, e.g. "123 cm\r\n", byte by byte into the existing uart_tx through a start/busy handshake.
- This gives a PC-side log of every SR04 measurement.

Parameters:
- SEND_UNITS, 1, when 1 the frame is the 3 digits + " cm" + CR LF (8 bytes); when 0 it is the 3 digits + CR LF (5 bytes).
- MAX_DIST, 999, distances above this value are clamped to it before conversion (must be ≤ 999).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- dist_done  input  1  one-cycle pulse: distance is valid this cycle
- distance  input  10  measured distance in cm, unsigned
- tx_busy  input  1  uart_tx busy; high from the cycle after an accepted tx_start until the stop bit ends
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data
- tx_data  output  8  byte to send; stable from the tx_start cycle until the byte completes
- busy  output  1  high whenever state ≠ IDLE
- overrun  output  1  one-cycle pulse when a dist_done is dropped

Behaviour:
- Reset values (sync rst, takes effect on the next edge): state = IDLE, tx_start = 0, tx_data = 8'h00, busy = 0, overrun = 0, all counters and registers 0.
- Reset mid-frame abandons the frame; no further tx_start is issued.
- States: IDLE, CONV, SEND, GUARD, HOLD.
- IDLE
  - dist_done = 1 at edge N: latch min(distance, MAX_DIST) and go to CONV.
- CONV (double-dabble)
  - Occupies exactly 10 cycles (N+1 … N+10).
  - Each cycle: add 3 to every BCD nibble ≥ 5, then shift {bcd[11:0], bin[9:0]} left by 1.
  - Iteration counter runs 0..9; after the 10th iteration go to SEND with byte index = 0.
- SEND
  - If tx_busy = 0: drive tx_data = frame[idx], pulse tx_start for 1 cycle, go to GUARD.
  - Otherwise stay in SEND; tx_start stays 0.
  - Earliest first tx_start is cycle N+11.
- GUARD
  - Exactly 1 cycle; tx_busy is ignored. Covers the one-cycle busy rise latency. Go to HOLD.
- HOLD
  - Wait for tx_busy = 0.
  - Then, if idx = last index: go to IDLE. Otherwise idx += 1 and go to SEND.
- Frame contents
  - Bytes 0–2: 8'h30 + hundreds, tens, ones digit. Leading zeros are always sent; width is fixed at 3.
  - SEND_UNITS = 1: then 8'h20, 8'h63, 8'h6D, 8'h0D, 8'h0A.
  - SEND_UNITS = 0: then 8'h0D, 8'h0A.
- Overrun
  - dist_done while busy = 1 (any non-IDLE state, including the final HOLD cycle) is dropped.
  - overrun pulses in the same cycle; the current frame is unaffected.
- Back-to-back frames: the frame end (HOLD → IDLE) and a new dist_done in the same cycle count as an overrun. The next frame needs a dist_done while in IDLE.
- tx_busy held high indefinitely: the block waits with no timeout. tx_start is never asserted while tx_busy = 1.
- tx_start and overrun are registered outputs. busy is decoded from the state register.

Decomposition:
- Shared package sonic_pkg holds:
  - State encoding (3-bit localparams).
  - ASCII constants: ASC_ZERO = 8'h30, ASC_SP, ASC_C, ASC_M, ASC_CR, ASC_LF.
  - Distance width DIST_W = 10, also used by sr04_ctrl and fnd_ctrl.
- One sub-module: bcd_dd_seq, the iterative 10-bit → 3-digit double-dabble.
  - Ports: start, bin, done, bcd[11:0].
  - Reused later by fnd_ctrl.
- The FSM, frame mux and handshake stay in the top module.

Test Plan:
- distance = 123, tx_busy model 20 cycles per byte → bytes 31 32 33 20 63 6D 0D 0A in order; first tx_start at dist_done + 11 cycles; busy falls after the 8th byte.
- distance = 7 → "007 cm\r\n" (30 30 37 …). distance = 0 → 30 30 30 ….
- distance = 1023 and distance = 1000 → both send 39 39 39 (clamped to MAX_DIST).
- Second dist_done during byte 3 → overrun = 1 for one cycle; frame bytes unchanged; no second frame follows.
- tx_busy forced high for 500 cycles entering SEND → tx_start stays 0 until tx_busy falls, then pulses once.
- rst pulsed while in HOLD after byte 2 → next edge: tx_start = 0, busy = 0, state IDLE; a new dist_done (distance = 45) then yields a full "045 cm\r\n". Repeat with SEND_UNITS = 0 → 30 34 35 0D 0A only.
